regfile_mp: RTL and testbench

Parametrised successor to the integer register file: configurable data width and depth, two combinational read ports, one byte-strobed write port, and an optional hardwired-zero register. It adds optional write-to-read bypass, a per-register pending-write scoreboard for the issue stage, and a sequential bulk-clear engine. It sits between decode (reads, reservations) and writeback (writes) in the CPU datapath.

---
 rtl/regfile_mp.sv | 148 ++++++++++++++
 tb/tb_regfile_mp.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised register file: two combinational read ports, one byte-strobed write port,
// optional zero register and write bypass, pending-write scoreboard and a bulk-clear engine.

module regfile_mp_rdport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0] stored,
  input  logic                  pend,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_merged,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy
);
  logic byp_hit, zero_hit;

  assign byp_hit  = BYPASS && wr_en && (wr_idx == idx);
  assign zero_hit = ZERO_REG && (idx == '0);

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (en && !zero_hit) begin
      data = byp_hit ? wr_merged : stored;
      busy = byp_hit ? 1'b0 : pend;
    end
  end
endmodule

module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable_a,
  input  logic [ADDR_WIDTH-1:0]   index_a,
  output logic [DATA_WIDTH-1:0]   output_a,
  output logic                    busy_a,
  input  logic                    enable_b,
  input  logic [ADDR_WIDTH-1:0]   index_b,
  output logic [DATA_WIDTH-1:0]   output_b,
  output logic                    busy_b,
  input  logic                    enable_write,
  input  logic [ADDR_WIDTH-1:0]   index_write,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  input  logic                    reserve_valid,
  input  logic [ADDR_WIDTH-1:0]   reserve_index,
  input  logic                    clear_start,
  output logic                    clear_busy
);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NB        = DATA_WIDTH / 8;
  localparam int NUM_PORTS = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                             state, state_nxt;
  logic [ADDR_WIDTH-1:0]              cnt;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   regs;
  logic [DEPTH-1:0]                   pending;
  logic [DATA_WIDTH-1:0]              wmask, wr_merged;
  logic                               wr_en, rsv_en, clr_go;

  logic [NUM_PORTS-1:0]                 rd_en, rd_busy;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_idx;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  assign clear_busy = (state == CLEAR);
  assign clr_go     = (state == IDLE) && clear_start;
  // Register 0 writes/reservations are filtered here so storage and pending stay 0.
  assign wr_en  = enable_write  && !clear_busy && !(ZERO_REG && index_write == '0);
  assign rsv_en = reserve_valid && !clear_busy && !(ZERO_REG && reserve_index == '0);

  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign wmask[8*b +: 8] = {8{write_strobe[b]}};
  end
  assign wr_merged = (regs[index_write] & ~wmask) | (write_data & wmask);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (clear_start) state_nxt = CLEAR;
      CLEAR: if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clr_go)          cnt <= '0;
      else if (clear_busy) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        regs <= '0;
    else if (clear_busy) regs[cnt] <= '0;
    else if (wr_en)      regs[index_write] <= wr_merged;
  end

  // Reserve beats write on the same index; a clear start overrides both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    pending <= '0;
    else if (clr_go) pending <= '0;
    else begin
      if (wr_en)  pending[index_write]   <= 1'b0;
      if (rsv_en) pending[reserve_index] <= 1'b1;
    end
  end

  assign rd_en  = {enable_b, enable_a};
  assign rd_idx = {index_b, index_a};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile_mp_rdport #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .en       (rd_en[p]),
      .idx      (rd_idx[p]),
      .stored   (regs[rd_idx[p]]),
      .pend     (pending[rd_idx[p]]),
      .wr_en    (wr_en),
      .wr_idx   (index_write),
      .wr_merged(wr_merged),
      .data     (rd_data[p]),
      .busy     (rd_busy[p])
    );
  end

  assign output_a = rd_data[0];
  assign busy_a   = rd_busy[0];
  assign output_b = rd_data[1];
  assign busy_b   = rd_busy[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: write/strobe/bypass, zero register, scoreboard, clear engine.

module tb_regfile_mp;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable_a, enable_b, enable_write, reserve_valid, clear_start;
  logic [4:0]  index_a, index_b, index_write, reserve_index;
  logic [31:0] output_a, output_b, write_data;
  logic [3:0]  write_strobe;
  logic        busy_a, busy_b, clear_busy;

  int tests = 0;
  int fails = 0;
  int n;

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .enable_a(enable_a), .index_a(index_a), .output_a(output_a), .busy_a(busy_a),
    .enable_b(enable_b), .index_b(index_b), .output_b(output_b), .busy_b(busy_b),
    .enable_write(enable_write), .index_write(index_write), .write_data(write_data),
    .write_strobe(write_strobe), .reserve_valid(reserve_valid), .reserve_index(reserve_index),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2-3 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d, input logic [3:0] s);
    enable_write = 1'b1; index_write = idx; write_data = d; write_strobe = s;
  endtask

  initial begin
    reset_n = 1'b0;
    enable_a = 1'b1; index_a = 5'd5; enable_b = 1'b0; index_b = 5'd0;
    enable_write = 1'b0; index_write = 5'd0; write_data = '0; write_strobe = '0;
    reserve_valid = 1'b0; reserve_index = 5'd0; clear_start = 1'b0;
    #12;
    chk("reset_out_a", output_a, 32'h0);
    chk("reset_busy_a", {31'b0, busy_a}, 32'h0);
    chk("reset_clear_busy", {31'b0, clear_busy}, 32'h0);
    reset_n = 1'b1;

    // full write with bypass, then from storage
    wr(5'd5, 32'h12345678, 4'b1111);
    #1 chk("bypass_full", output_a, 32'h12345678);
    tick(); enable_write = 1'b0;
    #1 chk("stored_full", output_a, 32'h12345678);

    // partial strobe merge
    wr(5'd5, 32'hAABBCCDD, 4'b0101);
    #1 chk("bypass_strobe", output_a, 32'h12BB56DD);
    tick(); enable_write = 1'b0;
    #1 chk("stored_strobe", output_a, 32'h12BB56DD);
    enable_a = 1'b0;
    #1 chk("disabled_out_a", output_a, 32'h0);
    enable_a = 1'b1;

    // zero register ignores writes and reservations
    index_a = 5'd0; wr(5'd0, 32'd103, 4'b1111);
    #1 chk("zero_bypass", output_a, 32'h0);
    tick(); enable_write = 1'b0;
    #1 chk("zero_stored", output_a, 32'h0);
    reserve_valid = 1'b1; reserve_index = 5'd0;
    tick(); reserve_valid = 1'b0;
    #1 chk("zero_busy", {31'b0, busy_a}, 32'h0);

    // scoreboard
    enable_b = 1'b1; index_b = 5'd12;
    reserve_valid = 1'b1; reserve_index = 5'd12;
    #1 chk("busy_before_edge", {31'b0, busy_b}, 32'h0);
    tick(); reserve_valid = 1'b0;
    #1 chk("busy_after_reserve", {31'b0, busy_b}, 32'h1);
    enable_b = 1'b0;
    #1 chk("busy_disabled", {31'b0, busy_b}, 32'h0);
    enable_b = 1'b1;
    wr(5'd12, 32'd103, 4'b1111);
    #1 chk("busy_bypass", {31'b0, busy_b}, 32'h0);
    chk("out_b_bypass", output_b, 32'd103);
    tick(); enable_write = 1'b0;
    #1 chk("busy_after_write", {31'b0, busy_b}, 32'h0);
    chk("out_b_stored", output_b, 32'd103);
    wr(5'd12, 32'h99, 4'b0001); reserve_valid = 1'b1; reserve_index = 5'd12;
    #1 chk("busy_wr_rsv_bypass", {31'b0, busy_b}, 32'h0);
    tick(); enable_write = 1'b0; reserve_valid = 1'b0;
    #1 chk("busy_rsv_wins", {31'b0, busy_b}, 32'h1);
    chk("out_b_low_byte", output_b, 32'h99);

    // fill r1..r31 then bulk clear
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'h01010101 * i, 4'b1111);
      tick();
    end
    enable_write = 1'b0;
    index_a = 5'd17;
    #1 chk("filled_r17", output_a, 32'h11111111);
    clear_start = 1'b1; reserve_valid = 1'b1; reserve_index = 5'd7;
    tick(); clear_start = 1'b0; reserve_valid = 1'b0;
    #1 chk("clear_busy_rise", {31'b0, clear_busy}, 32'h1);
    n = 0;
    while (clear_busy && n < 40) begin
      n++;
      if (n == 5) begin
        wr(5'd3, 32'hFFFFFFFF, 4'b1111); reserve_valid = 1'b1; reserve_index = 5'd4;
      end else begin
        enable_write = 1'b0; reserve_valid = 1'b0;
      end
      tick();
    end
    enable_write = 1'b0; reserve_valid = 1'b0;
    chk("clear_cycles", n, 32'd32);
    for (int i = 0; i < 32; i++) begin
      index_a = 5'(i);
      #1 chk($sformatf("cleared_r%0d", i), output_a, 32'h0);
      chk($sformatf("cleared_busy_r%0d", i), {31'b0, busy_a}, 32'h0);
    end
    wr(5'd9, 32'h55, 4'b1111); index_a = 5'd9;
    tick(); enable_write = 1'b0;
    #1 chk("write_after_clear", output_a, 32'h55);

    // reset in the middle of a clear
    wr(5'd20, 32'hDEADBEEF, 4'b1111);
    tick(); enable_write = 1'b0;
    index_a = 5'd20;
    #1 chk("r20_before_clear", output_a, 32'hDEADBEEF);
    clear_start = 1'b1;
    tick(); clear_start = 1'b0;
    repeat (10) tick();
    #1 chk("mid_clear_busy", {31'b0, clear_busy}, 32'h1);
    chk("r20_not_yet_cleared", output_a, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1 chk("reset_abort_busy", {31'b0, clear_busy}, 32'h0);
    chk("reset_abort_r20", output_a, 32'h0);
    index_a = 5'd9;
    #1 chk("reset_abort_r9", output_a, 32'h0);
    #3 reset_n = 1'b1;
    wr(5'd2, 32'hCAFE, 4'b0011); index_a = 5'd2;
    tick(); enable_write = 1'b0;
    #1 chk("write_after_reset", output_a, 32'hCAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
